// File: rtl/mig_arb_pkg.sv
// ---------------------------------------------------------------------------
// mig_arb_pkg
//
// Shared definitions for the memory-controller request arbiter slice:
//   - default DDR command address / data widths
//   - command word width helper ({we, adr, wdata})
//   - command-type encodings written into the command FIFO
//   - read-return tag encodings held in the in-order tag FIFO
//   - issue FSM state type
// ---------------------------------------------------------------------------
package mig_arb_pkg;

  localparam int ADRW_DEF = 28;
  localparam int DATW_DEF = 128;
  localparam int CMDW_DEF = 1 + ADRW_DEF + DATW_DEF;

  // Number of reads that may be outstanding towards the DDR controller.
  localparam int TAG_DEPTH = 4;

  // Command type carried in the top bit of the command word.
  localparam logic CMD_RD = 1'b0;
  localparam logic CMD_WR = 1'b1;

  // Owner of a returning read word.
  localparam logic TAG_IC = 1'b0;
  localparam logic TAG_DC = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_e;

  // Width of one command word for a given address/data width.
  function automatic int cmd_width(input int adrw, input int datw);
    return 1 + adrw + datw;
  endfunction

endpackage

// File: rtl/arb_tag_fifo.sv
// ---------------------------------------------------------------------------
// arb_tag_fifo
//
// Four-entry, one-bit-wide in-order FIFO remembering which requester owns
// each outstanding read. Entries leave in the order their reads were issued,
// which matches the order the DDR controller returns data.
//
// Ports:
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset, empties the FIFO
//   push      in   write push_tag at the tail (ignored when full)
//   push_tag  in   tag to store (TAG_IC / TAG_DC)
//   pop       in   drop the head entry (ignored when empty)
//   full      out  four entries held
//   empty     out  no entries held
//   head      out  tag at the head of the FIFO
// ---------------------------------------------------------------------------
module arb_tag_fifo
  import mig_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic push_tag,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  logic [TAG_DEPTH-1:0] mem;
  logic [1:0]           wptr;
  logic [1:0]           rptr;
  logic [2:0]           count;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count == 3'd4);
  assign empty   = (count == 3'd0);
  assign head    = mem[rptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Two-bit pointers wrap naturally modulo four; the separate count
  // disambiguates full from empty when the pointers are equal. A push and a
  // pop in the same cycle move both pointers and leave the count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem   <= '0;
      wptr  <= 2'd0;
      rptr  <= 2'd0;
      count <= 3'd0;
    end else begin
      if (do_push) begin
        mem[wptr] <= push_tag;
        wptr      <= wptr + 2'd1;
      end
      if (do_pop) begin
        rptr <= rptr + 2'd1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mig_req_arb.sv
// ---------------------------------------------------------------------------
// mig_req_arb
//
// Arbitrates i-cache reads and d-cache reads/writes onto a single DDR
// command async FIFO, and routes data from the read-return FIFO back to the
// requester that issued each read.
//
// Ports:
//   clk         in   single clock
//   rst_n       in   asynchronous active-low reset
//   ic_req      in   i-cache read request, held until ic_gnt
//   ic_adr      in   i-cache read address
//   ic_gnt      out  one-cycle grant pulse to the i-cache
//   dc_req      in   d-cache request, held until dc_gnt
//   dc_we       in   d-cache command type (1 = write, 0 = read)
//   dc_adr      in   d-cache address
//   dc_wdata    in   d-cache write data
//   dc_gnt      out  one-cycle grant pulse to the d-cache
//   cq_wen      out  command FIFO push strobe
//   cq_wqfull   in   command FIFO full (asserts with two entries still free)
//   cq_wdata    out  command word {we, adr, wdata}
//   rq_rqempty  in   read-return FIFO empty
//   rq_rnext    out  read-return FIFO pop strobe (combinational)
//   rq_rdata    in   read-return FIFO head data
//   rdata       out  returned read data, shared by both requesters
//   ic_rvalid   out  rdata belongs to the i-cache
//   dc_rvalid   out  rdata belongs to the d-cache
//   err         out  sticky: return data arrived with no read outstanding
// ---------------------------------------------------------------------------
module mig_req_arb
  import mig_arb_pkg::*;
#(
  parameter int ADRW = ADRW_DEF,
  parameter int DATW = DATW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ic_req,
  input  logic [ADRW-1:0]      ic_adr,
  output logic                 ic_gnt,
  input  logic                 dc_req,
  input  logic                 dc_we,
  input  logic [ADRW-1:0]      dc_adr,
  input  logic [DATW-1:0]      dc_wdata,
  output logic                 dc_gnt,
  output logic                 cq_wen,
  input  logic                 cq_wqfull,
  output logic [ADRW+DATW:0]   cq_wdata,
  input  logic                 rq_rqempty,
  output logic                 rq_rnext,
  input  logic [DATW-1:0]      rq_rdata,
  output logic [DATW-1:0]      rdata,
  output logic                 ic_rvalid,
  output logic                 dc_rvalid,
  output logic                 err
);

  localparam int CMDW = cmd_width(ADRW, DATW);

  arb_state_e      state;
  logic            prio_dc;
  logic            win_dc;
  logic [CMDW-1:0] pend_cmd;

  logic            ic_elig;
  logic            dc_elig;
  logic            win;
  logic            pick_dc;
  logic [CMDW-1:0] win_cmd;
  logic            tag_push;
  logic            tag_push_val;

  logic            tag_full;
  logic            tag_empty;
  logic            tag_head;

  arb_tag_fifo u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (tag_push),
    .push_tag (tag_push_val),
    .pop      (rq_rnext),
    .full     (tag_full),
    .empty    (tag_empty),
    .head     (tag_head)
  );

  // Eligibility and winner selection, evaluated only while IDLE.
  // A requester whose grant is pulsing this cycle still shows req=1 for the
  // command just issued, so it is masked to avoid serving it twice.
  // Writes need no tag slot, so a full tag FIFO only blocks reads.
  // prio_dc set means the d-cache wins a tie (the i-cache was granted last).
  always_comb begin
    ic_elig      = 1'b0;
    dc_elig      = 1'b0;
    win          = 1'b0;
    pick_dc      = 1'b0;
    win_cmd      = '0;
    tag_push     = 1'b0;
    tag_push_val = TAG_IC;
    if (state == IDLE) begin
      ic_elig = ic_req & ~ic_gnt & ~cq_wqfull & ~tag_full;
      dc_elig = dc_req & ~dc_gnt & ~cq_wqfull & (dc_we | ~tag_full);
    end
    win     = ic_elig | dc_elig;
    pick_dc = dc_elig & (~ic_elig | prio_dc);
    if (pick_dc) begin
      win_cmd = {(dc_we ? CMD_WR : CMD_RD), dc_adr, dc_wdata};
    end else begin
      win_cmd = {CMD_RD, ic_adr, {DATW{1'b0}}};
    end
    // The tag is claimed at the win so the next IDLE cycle already sees the
    // updated occupancy.
    tag_push     = win & (~pick_dc | (dc_we == CMD_RD));
    tag_push_val = pick_dc ? TAG_DC : TAG_IC;
  end

  // Issue FSM. The winner's command is captured in IDLE and presented as a
  // registered push while leaving ISSUE, so the command FIFO strobe and the
  // grant land two cycles after the request and at most every other cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      prio_dc  <= 1'b0;
      win_dc   <= 1'b0;
      pend_cmd <= '0;
      cq_wen   <= 1'b0;
      cq_wdata <= '0;
      ic_gnt   <= 1'b0;
      dc_gnt   <= 1'b0;
    end else begin
      cq_wen <= 1'b0;
      ic_gnt <= 1'b0;
      dc_gnt <= 1'b0;
      case (state)
        IDLE: begin
          if (win) begin
            state    <= ISSUE;
            win_dc   <= pick_dc;
            pend_cmd <= win_cmd;
            prio_dc  <= ~pick_dc;
          end
        end
        ISSUE: begin
          state    <= IDLE;
          cq_wen   <= 1'b1;
          cq_wdata <= pend_cmd;
          ic_gnt   <= ~win_dc;
          dc_gnt   <= win_dc;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pop the return FIFO whenever data is waiting and a read is outstanding.
  assign rq_rnext = ~rq_rqempty & ~tag_empty;

  // Return path: capture the popped word and flag its owner for one cycle.
  // Data with no outstanding read is left in the FIFO and latches err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata     <= '0;
      ic_rvalid <= 1'b0;
      dc_rvalid <= 1'b0;
      err       <= 1'b0;
    end else begin
      ic_rvalid <= rq_rnext & (tag_head == TAG_IC);
      dc_rvalid <= rq_rnext & (tag_head == TAG_DC);
      if (rq_rnext) begin
        rdata <= rq_rdata;
      end
      if (~rq_rqempty & tag_empty) begin
        err <= 1'b1;
      end
    end
  end

endmodule
